// File: rtl/uart_mem_dump_pkg.sv
// Shared definitions for the UART memory dump block: FSM states, frame length,
// and the clock-to-baud divider helper.
package uart_mem_dump_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_mem_dump_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each DIV cycles.
// A load in the final stop-bit cycle chains the next frame with no idle gap.
module uart_mem_dump_tx_byte
  import uart_mem_dump_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       ready_o,
  output logic       ending_o
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d  = busy_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      busy_d  = 1'b1;
      tx_d    = 1'b0;
      shift_d = {1'b1, byte_i};
      bit_d   = 4'd0;
      cnt_d   = {CNT_W{1'b0}};
    end else if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = {CNT_W{1'b0}};
        if (bit_q == BIT_LAST) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          // Stop bit sits in shift_q[8] and drops into place after eight shifts.
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      shift_q <= 9'h1FF;
      bit_q   <= 4'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_o     = tx_q;
  assign ready_o  = ~busy_q;
  // One cycle before the stop bit ends, so the caller can register its next load.
  assign ending_o = busy_q && (bit_q == BIT_LAST) && (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_mem_dump.sv
// Walks a word range of memory and streams each 32-bit word out over UART,
// least significant byte first, so the host can read back what was loaded.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 128_000,
  parameter int ADDR_W      = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_adr_i,
  input  logic [ADDR_W:0]   word_cnt_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  input  logic [31:0]       mem_dat_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   REM_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W-1:0] ADR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_q, load_d;
  logic [7:0]        tx_byte_s;
  logic              tx_ready_s;
  logic              tx_ending_s;

  assign tx_byte_s = word_q[{byte_idx_q, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    mem_rd_d   = 1'b0;
    mem_adr_d  = mem_adr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_i && tx_ready_s) begin
          addr_d = base_adr_i;
          rem_d  = word_cnt_i;
          busy_d = 1'b1;
          // An empty range still passes through NEXT so busy_o is visible for one cycle.
          if (word_cnt_i == REM_ZERO) begin
            state_d = ST_NEXT;
          end else begin
            state_d   = ST_FETCH;
            mem_rd_d  = 1'b1;
            mem_adr_d = base_adr_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        // Read data is valid the cycle after the strobe; latch it on entry to LOAD.
        word_d     = mem_dat_i;
        byte_idx_d = 2'd0;
        load_d     = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (tx_ending_s) begin
          if (byte_idx_q == 2'd3) begin
            state_d = ST_NEXT;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            load_d     = 1'b1;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_NEXT: begin
        addr_d = addr_q + ADR_ONE;
        rem_d  = (rem_q == REM_ZERO) ? REM_ZERO : rem_q - REM_ONE;
        if (rem_q <= REM_ONE) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d   = ST_FETCH;
          mem_rd_d  = 1'b1;
          mem_adr_d = addr_q + ADR_ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      rem_q      <= REM_ZERO;
      word_q     <= 32'h0000_0000;
      byte_idx_q <= 2'd0;
      mem_rd_q   <= 1'b0;
      mem_adr_q  <= {ADDR_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      mem_rd_q   <= mem_rd_d;
      mem_adr_q  <= mem_adr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_q     <= load_d;
    end
  end

  uart_mem_dump_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clock   (clock),
    .reset   (reset),
    .load_i  (load_q),
    .byte_i  (tx_byte_s),
    .tx_o    (tx_o),
    .ready_o (tx_ready_s),
    .ending_o(tx_ending_s)
  );

  assign mem_rd_o  = mem_rd_q;
  assign mem_adr_o = mem_adr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Scoreboard bench for uart_mem_dump: stimulus pushes expected reads, frames and
// done timing; independent monitors pop and compare as the DUT produces them.
module tb_uart_mem_dump;

  localparam int DIV      = 16;
  localparam int WORD_CYC = 643;
  localparam int FRM_CYC  = 160;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [13:0] base_adr_i = 14'h0;
  logic [14:0] word_cnt_i = 15'h0;
  logic        mem_rd_o;
  logic [13:0] mem_adr_o;
  logic [31:0] mem_dat_i;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  uart_mem_dump #(.CLK_FREQ_HZ(16), .BAUD(1), .ADDR_W(14)) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .base_adr_i(base_adr_i),
    .word_cnt_i(word_cnt_i), .mem_rd_o(mem_rd_o), .mem_adr_o(mem_adr_o),
    .mem_dat_i(mem_dat_i), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: data valid for two cycles after a strobe, garbage otherwise.
  logic [31:0] mem [0:16383];
  logic        rd_d1 = 1'b0;
  always @(posedge clock) begin
    rd_d1 <= mem_rd_o;
    if (mem_rd_o) mem_dat_i <= mem[mem_adr_o];
    else if (!rd_d1) mem_dat_i <= 32'hA5A5_A5A5;
  end

  typedef struct { logic [7:0] b; int c; } frame_t;
  logic [13:0] exp_adr_q[$];
  frame_t      exp_frm_q[$];
  int          exp_done_q[$];
  logic [7:0]  want_bytes[$];
  bit          mon_en = 1'b1;
  int          done_total = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic extra(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // Read-strobe monitor.
  initial forever begin
    @(negedge clock);
    if (mon_en && reset && mem_rd_o === 1'b1) begin
      if (exp_adr_q.size() == 0) extra("extra_read", mem_adr_o);
      else chk("read_adr", mem_adr_o, exp_adr_q.pop_front());
    end
  end

  // Done-pulse monitor.
  initial forever begin
    @(negedge clock);
    if (done_o === 1'b1) begin
      done_total++;
      if (mon_en) begin
        if (exp_done_q.size() == 0) extra("extra_done", cyc);
        else chk("done_cycle", cyc, exp_done_q.pop_front());
        chk("busy_at_done", busy_o, 1'b0);
      end
    end
  end

  // UART monitor: detects the start edge, samples each bit mid-way.
  initial begin
    int st;
    int off;
    int bn;
    logic [7:0] sh;
    bit act;
    frame_t f;
    act = 1'b0;
    st = 0;
    sh = 8'h00;
    forever begin
      @(negedge clock);
      if (!mon_en || !reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx_o === 1'b0) begin
          act = 1'b1;
          st = cyc;
        end
      end else begin
        off = cyc - st;
        if (off % DIV == DIV / 2) begin
          bn = off / DIV;
          if (bn == 0) chk("start_bit", tx_o, 1'b0);
          else if (bn <= 8) sh[bn-1] = tx_o;
          else begin
            chk("stop_bit", tx_o, 1'b1);
            act = 1'b0;
            if (exp_frm_q.size() == 0) extra("extra_frame", sh);
            else begin
              f = exp_frm_q.pop_front();
              chk("frame_byte", sh, f.b);
              chk("frame_start_cycle", st, f.c);
            end
          end
        end
      end
    end
  end

  task automatic dump(input logic [13:0] base, input logic [14:0] cnt, input int pulse_at);
    int e0;
    int lim;
    int target;
    frame_t f;
    @(negedge clock);
    start_i = 1'b1;
    base_adr_i = base;
    word_cnt_i = cnt;
    e0 = cyc + 1;
    for (int w = 0; w < int'(cnt); w++) begin
      exp_adr_q.push_back(base + 14'(w));
      for (int j = 0; j < 4; j++) begin
        f.b = want_bytes.pop_front();
        f.c = e0 + 3 + WORD_CYC * w + FRM_CYC * j;
        exp_frm_q.push_back(f);
      end
    end
    exp_done_q.push_back((cnt == 15'd0) ? e0 + 1 : e0 + WORD_CYC * int'(cnt));
    target = done_total + 1;
    @(negedge clock);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
    chk("tx_idle_after_start", tx_o, 1'b1);
    lim = (cnt == 15'd0) ? 10 : WORD_CYC * int'(cnt) + 20;
    for (int i = 0; i < lim && done_total < target; i++) begin
      @(negedge clock);
      if (pulse_at > 0 && cyc == e0 + pulse_at) begin
        start_i = 1'b1;
        base_adr_i = 14'h1234;
        word_cnt_i = 15'd5;
      end else if (pulse_at > 0 && cyc == e0 + pulse_at + 1) begin
        start_i = 1'b0;
      end
    end
    chk("done_seen", done_total >= target, 1'b1);
    repeat (2) @(negedge clock);
    chk("tx_idle_after_done", tx_o, 1'b1);
    chk("busy_low_after_done", busy_o, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int dc;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[14'h0010] = 32'h1234_5678;
    mem[14'h3FFF] = 32'h1122_3344;
    mem[14'h0000] = 32'hA1B2_C3D4;
    mem[14'h0040] = 32'h0BAD_F00D;
    mem[14'h0020] = 32'hCAFE_F00D;
    mem[14'h0100] = 32'hDEAD_BEEF;
    mem[14'h0200] = 32'h9A3C_5E71;
    mem[14'h0201] = 32'h00FF_00FF;
    mem[14'h0202] = 32'h8000_0001;

    repeat (3) @(negedge clock);
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_mem_rd", mem_rd_o, 1'b0);
    chk("rst_mem_adr", mem_adr_o, 14'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    want_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    dump(14'h0010, 15'd1, 0);

    dump(14'h0000, 15'd0, 0);

    want_bytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    dump(14'h3FFF, 15'd2, 0);

    want_bytes = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
    dump(14'h0040, 15'd1, 100);

    // Abort a dump with reset in the second data bit of the first byte.
    mon_en = 1'b0;
    @(negedge clock);
    start_i = 1'b1;
    base_adr_i = 14'h0020;
    word_cnt_i = 15'd1;
    e0 = cyc + 1;
    @(negedge clock);
    start_i = 1'b0;
    while (cyc < e0 + 43) @(negedge clock);
    chk("pre_reset_busy", busy_o, 1'b1);
    reset = 1'b0;
    dc = done_total;
    @(negedge clock);
    chk("abort_tx", tx_o, 1'b1);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    chk("abort_mem_rd", mem_rd_o, 1'b0);
    chk("abort_mem_adr", mem_adr_o, 14'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_no_done", done_total, dc);
    chk("abort_tx_idle", tx_o, 1'b1);
    mon_en = 1'b1;

    want_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    dump(14'h0100, 15'd1, 0);

    want_bytes = '{8'h71, 8'h5E, 8'h3C, 8'h9A, 8'hFF, 8'h00, 8'hFF, 8'h00,
                   8'h01, 8'h00, 8'h00, 8'h80};
    dump(14'h0200, 15'd3, 0);

    repeat (20) @(negedge clock);
    chk("pending_reads", exp_adr_q.size(), 0);
    chk("pending_frames", exp_frm_q.size(), 0);
    chk("pending_dones", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
